// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-cycle logic/add/sub, bit-serial shifts, registered result over valid/ready.
// Optional SLT opcode (0111) when ALU_EXEC_SLT_EN is defined; otherwise 0111 is reported illegal.
module alu_exec_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  illegal
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
`ifdef ALU_EXEC_SLT_EN
  localparam logic [3:0] OP_SLT = 4'b0111;
`endif

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [1:0]              sdir_q, sdir_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    zero_q, zero_d;
  logic                    illegal_q, illegal_d;
  logic                    out_valid_q, out_valid_d;

  logic [SHAMT_WIDTH-1:0]  shamt;
  logic                    is_shift;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   imm_res;
  logic                    imm_ill;
  logic [DATA_WIDTH-1:0]   step;

  assign shamt    = operand_b[SHAMT_WIDTH-1:0];
  assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready) && !rst;
  assign accept   = in_valid && in_ready;

  // Result for anything that completes on the accept edge, including shift-by-zero.
  always_comb begin
    imm_res = '0;
    imm_ill = 1'b0;
    case (alu_ctrl)
      OP_AND:                 imm_res = operand_a & operand_b;
      OP_OR:                  imm_res = operand_a | operand_b;
      OP_ADD:                 imm_res = operand_a + operand_b;
      OP_SUB:                 imm_res = operand_a - operand_b;
      OP_SLL, OP_SRL, OP_SRA: imm_res = operand_a;
`ifdef ALU_EXEC_SLT_EN
      OP_SLT: imm_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
`endif
      default:                imm_ill = 1'b1;
    endcase
  end

  // sdir encodes alu_ctrl[1:0]: 00 SLL, 01 SRL, 10 SRA.
  always_comb begin
    case (sdir_q)
      2'b00:   step = {work_q[DATA_WIDTH-2:0], 1'b0};
      2'b01:   step = {1'b0, work_q[DATA_WIDTH-1:1]};
      default: step = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    sdir_d      = sdir_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            work_d  = operand_a;
            cnt_d   = shamt;
            sdir_d  = alu_ctrl[1:0];
            state_d = SHIFT;
          end else begin
            result_d    = imm_res;
            zero_d      = (imm_res == '0);
            illegal_d   = imm_ill;
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q - SHAMT_WIDTH'(1);
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          result_d    = step;
          zero_d      = (step == '0);
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      sdir_q      <= 2'b00;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      sdir_q      <= sdir_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases plus random ops against a whole-operation reference model.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Whole-operation reference: final value computed in one step, latency from the shift count.
  task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic ill, output int lat);
    int n;
    logic signed [31:0] sa;
    n   = int'(b % 32);
    sa  = a;
    r   = 32'd0;
    ill = 1'b0;
    lat = 1;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b1000: begin r = a << n;   lat = (n == 0) ? 1 : n + 1; end
      4'b1001: begin r = a >> n;   lat = (n == 0) ? 1 : n + 1; end
      4'b1010: begin r = sa >>> n; lat = (n == 0) ? 1 : n + 1; end
`ifdef ALU_EXEC_SLT_EN
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`endif
      default: ill = 1'b1;
    endcase
  endtask

  // Entered and left on a falling edge; hold>0 stalls the consumer for that many cycles.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        ei;
    int          el;
    int          lat;
    model(c, a, b, er, ei, el);
    in_valid  = 1'b1;
    alu_ctrl  = c;
    operand_a = a;
    operand_b = b;
    out_ready = 1'b1;
    #1 check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    alu_ctrl  = 4'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("in_ready_busy", in_ready, 0);
      @(negedge clk);
      lat++;
    end
    check("out_valid", out_valid, 1);
    check("latency", lat, el);
    check("result", result, er);
    check("zero", zero, (er == 32'd0) ? 1 : 0);
    check("illegal", illegal, ei);
    if (hold > 0) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      alu_ctrl  = 4'b0010;
      operand_a = $urandom;
      operand_b = $urandom;
      for (int i = 0; i < hold; i++) begin
        #1 check("in_ready_hold", in_ready, 0);
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_result", result, er);
        check("hold_illegal", illegal, ei);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      check("release", out_valid, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = 4'b0;
    operand_a = '0;
    operand_b = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_illegal", illegal, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1 check("in_ready_after_rst", in_ready, 1);
    @(negedge clk);

    run_op(4'b0010, 32'd5, 32'd7, 0);
    run_op(4'b0110, 32'd9, 32'd9, 0);
    run_op(4'b0000, 32'hF0F0_0000, 32'h0F0F_FFFF, 0);
    run_op(4'b1000, 32'h1, 32'd4, 0);
    run_op(4'b1010, 32'h8000_0000, 32'd3, 0);
    run_op(4'b1001, 32'h8000_0000, 32'd3, 0);
    run_op(4'b1000, 32'hDEAD_BEEF, 32'd32, 0);
    run_op(4'b1010, 32'h8000_0001, 32'd31, 0);
    run_op(4'b0010, 32'd1, 32'd1, 3);
    run_op(4'b1111, 32'h1234_5678, 32'h1, 0);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 1);

    // Reset in the middle of a 20-step shift must abort it without a result.
    in_valid  = 1'b1;
    alu_ctrl  = 4'b1000;
    operand_a = 32'h1;
    operand_b = 32'd20;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    alu_ctrl  = 4'b0010;
    #1 check("in_ready_during_rst", in_ready, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    #1 check("in_ready_post_abort", in_ready, 1);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("abort_quiet", out_valid, 0);
    end
    run_op(4'b0010, 32'd100, 32'd23, 0);

    for (int i = 0; i < 300; i++) begin
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      int          h;
      case ($urandom_range(0, 3))
        0:       c = 4'($urandom_range(0, 15));
        1:       c = 4'b1000 + 4'($urandom_range(0, 2));
        default: c = (($urandom_range(0, 1)) == 0) ? 4'b0010 : 4'b0110;
      endcase
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'd0;
      if ($urandom_range(0, 7) == 0) b = a;
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(c, a, b, h);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
